mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
// - Round-robin arbiter and select sequencer for the shared 8:1 mux (data i[7:0], select s[2:0], out o).
// - Up to 8 requesters compete for the mux. The winner's index drives the mux select for a bounded hold window.
// - A one-hot grant tells the winner its input is routed to o.
// - Sits between requester logic and the mux; the mux itself stays external.
// PARAMETERS
// - N_REQ        8  number of requesters (= mux inputs); power of 2
// - SEL_W        3  select width, $clog2(N_REQ)
// - HOLD_CYCLES  4  maximum grant length in clk cycles; >=1
// - GAP_CYCLES   1  dead cycles after each grant, before next arbitration; >=0
// PORTS
// - clk         in   1       rising-edge clock
// - rst_n       in   1       asynchronous, active-low reset
// - req         in   N_REQ   request per requester; held high until served
// - gnt         out  N_REQ   one-hot grant, registered; all-zero when no grant
// - s           out  SEL_W   mux select, registered; index of current/last winner
// - busy        out  1       high while in GRANT
// - grant_done  out  1       one-cycle pulse on the last GRANT cycle
// - lock        in   1       only with RR_ARB_LOCK_EN; extends current grant
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - gnt=0, s=0, busy=0, grant_done=0, state=IDLE, hold counter=0.
//   - last-served pointer ptr=N_REQ-1, so requester 0 has top priority after reset.
// - States: IDLE, GRANT, GAP (2-bit encoding).
// - IDLE:
//   - req==0: stay in IDLE.
//   - Otherwise pick the first set req bit scanning ptr+1, ptr+2, ... (mod N_REQ).
//   - Next edge: GRANT, gnt=onehot(win), s=win, busy=1, cnt=0, ptr=win.
//   - Latency from req rising to gnt is 1 clk.
// - GRANT: cnt increments each cycle. The grant ends on the cycle when cnt==HOLD_CYCLES-1 OR req[ptr]==0.
//   - On that cycle grant_done=1.
//   - Next edge: gnt=0, busy=0; go to GAP if GAP_CYCLES>0, else IDLE.
// - GAP: gnt=0 for GAP_CYCLES cycles, then IDLE. Requests arriving in GAP are not lost; they are evaluated in IDLE.
// - With GAP_CYCLES=0 and continuous requests: each winner gets HOLD_CYCLES grant cycles plus one IDLE cycle.
// - s holds the last winner in IDLE/GAP, so o stays stable. s never changes during GRANT.
// - Fairness: a requester that just won has the lowest priority next round. With N active requesters, each waits at most N-1 grants.
// - Simultaneous events: the winner dropping req on the same cycle cnt hits HOLD_CYCLES-1 gives one grant_done pulse, not two.
// - req bits other than the winner's are ignored during GRANT/GAP.
// - Reset mid-GRANT: gnt, busy and grant_done clear immediately (async); ptr returns to N_REQ-1.
// - Counter width: $clog2(HOLD_CYCLES+1) bits; it saturates and never wraps.
// CONFIGURATION
// - Macro RR_ARB_LOCK_EN defined:
//   - lock port exists.
//   - In GRANT, lock=1 with req[ptr]=1 suppresses the HOLD_CYCLES limit; cnt saturates at HOLD_CYCLES-1.
//   - The grant ends on the first cycle with lock=0 and cnt at its limit, or when req[ptr]=0.
//   - lock is ignored outside GRANT.
// - Macro RR_ARB_LOCK_EN undefined: no lock port; grants always end by the HOLD_CYCLES/req rule.
// STRUCTURE
// - Package mux_arb_pkg holds:
//   - state enum arb_state_t {IDLE, GRANT, GAP}
//   - N_REQ and SEL_W constants
//   - onehot/index conversion functions
// - Sub-module rr_pick (combinational):
//   - inputs req, ptr; outputs win index and any_req.
//   - Rotating priority encoder: rotate req right by ptr+1, priority-encode, add the offset back mod N_REQ.
// TESTING
// - Reset release, req=8'h00 for 10 cycles -> gnt=0, s=0, busy=0 throughout.
// - req=8'h01 held -> gnt=8'h01 and s=0 one clk later, for 4 cycles. grant_done on the 4th. Then 1 GAP cycle, 1 IDLE cycle, re-grant.
// - req=8'hFF held, GAP_CYCLES=0 -> s sequences 0,1,2,...,7,0. Each gnt lasts 4 cycles; gnt always one-hot.
// - req=8'h24 (reqs 2 and 5), req[2] dropped on the 2nd grant cycle -> grant to 2 ends after 2 cycles, then gnt=8'h20, s=5.
// - rst_n pulsed low mid-GRANT to requester 6 -> gnt=0 and busy=0 immediately. After release with req=8'h41, requester 0 wins first.
// - RR_ARB_LOCK_EN, req=8'h08, lock held high for 10 cycles -> gnt=8'h08 for 10 cycles. Grant ends the cycle lock falls.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types, sizes and index helpers for the mux round-robin arbiter
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [SEL_W-1:0] to_index(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder: first set req bit after ptr, wrapping
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any_req
);

  logic [SEL_W-1:0] off;
  logic [SEL_W-1:0] k;
  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] lowest;

  always_comb begin
    off = ptr + SEL_W'(1);
    rot = '0;
    // rot[0] is the requester just after ptr, so the lowest set bit is the next in turn
    for (int i = 0; i < N_REQ; i++) begin
      k      = SEL_W'(i) + off;
      rot[i] = req[k];
    end
    lowest  = rot & (~rot + N_REQ'(1));
    win     = to_index(lowest) + off;
    any_req = |req;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving the shared 8:1 mux select (optional RR_ARB_LOCK_EN grant lock)
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
`ifdef RR_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] s,
  output logic             busy,
  output logic             grant_done
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [SEL_W-1:0] win;
  logic             any_req;
  logic             cnt_last;
  logic             grant_end;

  rr_pick u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .any_req (any_req)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    s_d        = s_q;
    grant_done = 1'b0;
    cnt_last   = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
`ifdef RR_ARB_LOCK_EN
    grant_end  = !req[ptr_q] || (cnt_last && !lock);
`else
    grant_end  = !req[ptr_q] || cnt_last;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          gnt_d   = onehot(win);
          s_d     = win;
          cnt_d   = '0;
          ptr_d   = win;
        end
      end
      GRANT: begin
        // saturate so a locked grant never wraps the counter
        cnt_d = cnt_last ? cnt_q : cnt_q + CNT_W'(1);
        if (grant_end) begin
          grant_done = 1'b1;
          gnt_d      = '0;
          cnt_d      = '0;
          gap_d      = '0;
          state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else                                 gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= SEL_W'(N_REQ - 1);
      gnt_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
    end
  end

  assign gnt  = gnt_q;
  assign s    = s_q;
  assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter (lock scenario only with RR_ARB_LOCK_EN)
module tb_mux_rr_arbiter;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] s;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_a, req_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] s_a, s_b;
  logic       busy_a, busy_b, done_a, done_b;
`ifdef RR_ARB_LOCK_EN
  logic       lock_a;
  logic       lock_b;
`endif

  obs_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  mux_rr_arbiter #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_a),
`ifdef RR_ARB_LOCK_EN
    .lock       (lock_a),
`endif
    .gnt        (gnt_a),
    .s          (s_a),
    .busy       (busy_a),
    .grant_done (done_a)
  );

  mux_rr_arbiter #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_b),
`ifdef RR_ARB_LOCK_EN
    .lock       (lock_b),
`endif
    .gnt        (gnt_b),
    .s          (s_b),
    .busy       (busy_b),
    .grant_done (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void push_exp(input logic [7:0] g, input logic [2:0] sel,
                                   input logic b, input logic d);
    obs_t e;
    e = '{gnt: g, s: sel, busy: b, done: d};
    exp_q.push_back(e);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
`ifdef RR_ARB_LOCK_EN
    lock_a = 1'b0;
    lock_b = 1'b0;
`endif
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst_n = 1'b1;
    req_a = '0;
    req_b = '0;
`ifdef RR_ARB_LOCK_EN
    lock_a = 1'b0;
    lock_b = 1'b0;
`endif
    #1;
    rst_n = 1'b0;
    #1;
    e = '0;
    o = {gnt_a, s_a, busy_a, done_a};
    checks++;
    if (o !== e) begin
      fails++;
      $display("FAIL reset_async_a: got gnt=%h s=%0d busy=%b done=%b, want all zero", o.gnt, o.s, o.busy, o.done);
    end
    o = {gnt_b, s_b, busy_b, done_b};
    checks++;
    if (o !== e) begin
      fails++;
      $display("FAIL reset_async_b: got gnt=%h s=%0d busy=%b done=%b, want all zero", o.gnt, o.s, o.busy, o.done);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #2;
      e = exp_q.pop_front();
      o = {gnt_a, s_a, busy_a, done_a};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_idle cyc %0d: got gnt=%h s=%0d busy=%b done=%b, want gnt=%h s=%0d busy=%b done=%b",
                 c, o.gnt, o.s, o.busy, o.done, e.gnt, e.s, e.busy, e.done);
      end
    end
  endtask

  task automatic test_single();
    obs_t e, o;
    do_reset();
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) push_exp(8'h01, 3'd0, 1'b1, k == 4);
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    push_exp(8'h01, 3'd0, 1'b1, 1'b0);
    push_exp(8'h01, 3'd0, 1'b1, 1'b0);
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      #1;
      req_a = 8'h01;
      #1;
      e = exp_q.pop_front();
      o = {gnt_a, s_a, busy_a, done_a};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL single_req cyc %0d: got gnt=%h s=%0d busy=%b done=%b, want gnt=%h s=%0d busy=%b done=%b",
                 c, o.gnt, o.s, o.busy, o.done, e.gnt, e.s, e.busy, e.done);
      end
    end
  endtask

  task automatic test_all_req_no_gap();
    obs_t e, o;
    int   n;
    do_reset();
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    for (int w = 0; w < 9; w++) begin
      for (int k = 1; k <= 4; k++) push_exp(8'h01 << (w % 8), 3'(w % 8), 1'b1, k == 4);
      push_exp(8'h00, 3'(w % 8), 1'b0, 1'b0);
    end
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      req_b = 8'hFF;
      #1;
      e = exp_q.pop_front();
      o = {gnt_b, s_b, busy_b, done_b};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL all_req cyc %0d: got gnt=%h s=%0d busy=%b done=%b, want gnt=%h s=%0d busy=%b done=%b",
                 c, o.gnt, o.s, o.busy, o.done, e.gnt, e.s, e.busy, e.done);
      end
    end
  endtask

  task automatic test_early_drop();
    obs_t e, o;
    do_reset();
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    push_exp(8'h04, 3'd2, 1'b1, 1'b0);
    push_exp(8'h04, 3'd2, 1'b1, 1'b1);
    push_exp(8'h00, 3'd2, 1'b0, 1'b0);
    push_exp(8'h00, 3'd2, 1'b0, 1'b0);
    push_exp(8'h20, 3'd5, 1'b1, 1'b0);
    push_exp(8'h20, 3'd5, 1'b1, 1'b0);
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      req_a = (c >= 2) ? 8'h20 : 8'h24;
      #1;
      e = exp_q.pop_front();
      o = {gnt_a, s_a, busy_a, done_a};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL early_drop cyc %0d: got gnt=%h s=%0d busy=%b done=%b, want gnt=%h s=%0d busy=%b done=%b",
                 c, o.gnt, o.s, o.busy, o.done, e.gnt, e.s, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    obs_t e, o;
    do_reset();
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    push_exp(8'h40, 3'd6, 1'b1, 1'b0);
    push_exp(8'h40, 3'd6, 1'b1, 1'b0);
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    push_exp(8'h01, 3'd0, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        @(posedge clk);
        #1;
        req_a = 8'h40;
        #1;
      end else if (c == 3) begin
        rst_n = 1'b0;
        #1;
      end else if (c == 4) begin
        @(posedge clk);
        #1;
        req_a = 8'h41;
        rst_n = 1'b1;
        #1;
      end else begin
        @(posedge clk);
        #2;
      end
      e = exp_q.pop_front();
      o = {gnt_a, s_a, busy_a, done_a};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_mid_grant step %0d: got gnt=%h s=%0d busy=%b done=%b, want gnt=%h s=%0d busy=%b done=%b",
                 c, o.gnt, o.s, o.busy, o.done, e.gnt, e.s, e.busy, e.done);
      end
    end
  endtask

`ifdef RR_ARB_LOCK_EN
  task automatic test_lock();
    obs_t e, o;
    do_reset();
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) push_exp(8'h08, 3'd3, 1'b1, 1'b0);
    push_exp(8'h08, 3'd3, 1'b1, 1'b1);
    push_exp(8'h00, 3'd3, 1'b0, 1'b0);
    for (int c = 0; c < 13; c++) begin
      @(posedge clk);
      #1;
      req_a  = 8'h08;
      lock_a = (c <= 10);
      #1;
      e = exp_q.pop_front();
      o = {gnt_a, s_a, busy_a, done_a};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL lock_hold cyc %0d: got gnt=%h s=%0d busy=%b done=%b, want gnt=%h s=%0d busy=%b done=%b",
                 c, o.gnt, o.s, o.busy, o.done, e.gnt, e.s, e.busy, e.done);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_req_no_gap();
    test_early_drop();
    test_reset_mid_grant();
`ifdef RR_ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
